// File: rtl/input_quantizer_if.sv
// Streaming feature input and packed-vector output of the input quantizer.
// The slave modport is the quantizer's view; master is the driving/consuming side.
interface input_quantizer_if #(
   parameter int unsigned NUM_FEATURES = 16,
   parameter int unsigned IN_W         = 16,
   parameter int unsigned BW           = 2
);

   logic                       s_valid;
   logic                       s_ready;
   logic [IN_W-1:0]            s_data;
   logic                       s_last;
   logic                       m_valid;
   logic                       m_ready;
   logic [NUM_FEATURES*BW-1:0] M0;
   logic                       err;

   modport slave (
      input  s_valid,
      input  s_data,
      input  s_last,
      input  m_ready,
      output s_ready,
      output m_valid,
      output M0,
      output err
   );

   modport master (
      output s_valid,
      output s_data,
      output s_last,
      output m_ready,
      input  s_ready,
      input  m_valid,
      input  M0,
      input  err
   );

endinterface

// File: rtl/input_quantizer.sv
// Quantizes signed feature words to BW-bit codes and packs NUM_FEATURES of them into a
// registered, held vector for the layer-0 neuron LUTs.
module input_quantizer #(
   parameter int unsigned            NUM_FEATURES = 16,
   parameter int unsigned            IN_W         = 16,
   parameter int unsigned            BW           = 2,
   parameter logic signed [IN_W-1:0] OFFSET       = '0,
   parameter int unsigned            SHIFT        = 8
) (
   input logic              clk,
   input logic              rst_n,
   input_quantizer_if.slave bus
);

   localparam int unsigned IdxW    = (NUM_FEATURES > 1) ? $clog2(NUM_FEATURES) : 1;
   localparam int unsigned VecW    = NUM_FEATURES * BW;
   localparam int unsigned MaxCode = (1 << BW) - 1;

   localparam logic [IdxW-1:0]       LastIdx  = IdxW'(NUM_FEATURES - 1);
   localparam logic signed [IN_W:0]  MaxCodeS = (IN_W + 1)'(MaxCode);

   logic [IdxW-1:0] idx_q, idx_d;
   logic [VecW-1:0] asm_q, asm_d;
   logic [VecW-1:0] vec_q, vec_d;
   logic            m_valid_q, m_valid_d;
   logic            err_q, err_d;

   logic signed [IN_W:0] diff;
   logic signed [IN_W:0] shifted;
   logic [BW-1:0]        code;
   logic                 last_slot;
   logic                 accept;
   logic [VecW-1:0]      merged;

   // One extra bit keeps the offset subtraction exact for any input/offset pair.
   always_comb begin
      diff    = $signed({bus.s_data[IN_W-1], bus.s_data}) - $signed({OFFSET[IN_W-1], OFFSET});
      shifted = diff >>> SHIFT;
      if (shifted < 0) begin
         code = '0;
      end else if (shifted > MaxCodeS) begin
         code = '1;
      end else begin
         code = shifted[BW-1:0];
      end
   end

   assign last_slot   = (idx_q == LastIdx);
   // Only the completing feature stalls, and only while an unconsumed vector is held.
   assign bus.s_ready = rst_n && (!last_slot || !m_valid_q || bus.m_ready);
   assign accept      = bus.s_valid && bus.s_ready;

   always_comb begin
      merged = asm_q;
      merged[int'(idx_q) * BW +: BW] = code;
   end

   always_comb begin
      idx_d     = idx_q;
      asm_d     = asm_q;
      vec_d     = vec_q;
      m_valid_d = m_valid_q && !bus.m_ready;
      err_d     = 1'b0;

      if (accept) begin
         asm_d = merged;
         if (last_slot) begin
            vec_d     = merged;
            m_valid_d = 1'b1;
            idx_d     = '0;
            err_d     = !bus.s_last;
         end else if (bus.s_last) begin
            // Short sample: drop it; stale slots are overwritten before the next emission.
            idx_d = '0;
            err_d = 1'b1;
         end else begin
            idx_d = idx_q + IdxW'(1);
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         idx_q     <= '0;
         asm_q     <= '0;
         vec_q     <= '0;
         m_valid_q <= 1'b0;
         err_q     <= 1'b0;
      end else begin
         idx_q     <= idx_d;
         asm_q     <= asm_d;
         vec_q     <= vec_d;
         m_valid_q <= m_valid_d;
         err_q     <= err_d;
      end
   end

   assign bus.m_valid = m_valid_q;
   assign bus.M0      = vec_q;
   assign bus.err     = err_q;

endmodule

// File: tb/tb_input_quantizer.sv
// Self-checking bench for input_quantizer: directed scenarios from the block's behaviour plus
// a randomized run against a queue-based reference model.
module tb_input_quantizer;

   localparam int NF     = 16;
   localparam int IN_W   = 16;
   localparam int BW     = 2;
   localparam int OFFSET = 0;
   localparam int SHIFT  = 8;

   logic clk;
   logic rst_n;
   int   n_tests;
   int   n_fail;

   logic [NF*BW-1:0] exp_vec;
   logic [NF*BW-1:0] held_vec;
   int               codes[NF];

   input_quantizer_if #(.NUM_FEATURES(NF), .IN_W(IN_W), .BW(BW)) bus ();

   input_quantizer #(
      .NUM_FEATURES(NF),
      .IN_W        (IN_W),
      .BW          (BW),
      .OFFSET      (16'sd0),
      .SHIFT       (SHIFT)
   ) dut (
      .clk  (clk),
      .rst_n(rst_n),
      .bus  (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // Reference quantizer: floor division by 2^SHIFT, then clamp to the code range.
   function automatic int quant(input logic [15:0] raw);
      int v;
      int d;
      int q;
      int div;
      v   = $signed(raw);
      d   = v - OFFSET;
      div = 1 << SHIFT;
      if (d >= 0) q = d / div;
      else q = -((-d + div - 1) / div);
      if (q < 0) q = 0;
      if (q > (1 << BW) - 1) q = (1 << BW) - 1;
      return q;
   endfunction

   function automatic logic [NF*BW-1:0] pack_codes();
      logic [NF*BW-1:0] v;
      v = '0;
      for (int i = 0; i < NF; i++) v[i*BW +: BW] = codes[i][BW-1:0];
      return v;
   endfunction

   task automatic push(input logic [15:0] data, input logic last, output bit acc);
      bus.s_valid = 1'b1;
      bus.s_data  = data;
      bus.s_last  = last;
      #1;
      acc = bus.s_ready;
      @(posedge clk);
      #1;
      bus.s_valid = 1'b0;
      bus.s_last  = 1'b0;
   endtask

   task automatic idle();
      @(posedge clk);
      #1;
   endtask

   // Streams a full random sample with correct framing; fills codes[] with expected codes.
   task automatic send_random_sample(input logic last_ok);
      bit          acc;
      logic [15:0] d;
      for (int i = 0; i < NF; i++) begin
         d        = 16'($urandom);
         codes[i] = quant(d);
         push(d, (i == NF - 1) && last_ok, acc);
      end
      exp_vec = pack_codes();
   endtask

   task automatic test_reset();
      rst_n       = 1'b0;
      bus.s_valid = 1'b0;
      bus.s_data  = '0;
      bus.s_last  = 1'b0;
      bus.m_ready = 1'b0;
      #1;
      n_tests++;
      if (bus.s_ready !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_sready: got %b want 0", bus.s_ready);
      end
      repeat (2) @(posedge clk);
      #2;
      rst_n = 1'b1;
      idle();
      n_tests++;
      if (bus.m_valid !== 1'b0 || bus.err !== 1'b0 || bus.M0 !== '0) begin
         n_fail++;
         $display("FAIL reset_outputs: got mv=%b err=%b M0=%h want 0/0/0",
                  bus.m_valid, bus.err, bus.M0);
      end
      n_tests++;
      if (bus.s_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL reset_release_sready: got %b want 1", bus.s_ready);
      end
   endtask

   task automatic test_quant_sweep();
      logic [15:0]      feats[NF];
      logic [NF*BW-1:0] literal;
      bit               acc;
      feats[0] = 16'h0000;
      feats[1] = 16'h0100;
      feats[2] = 16'h02FF;
      feats[3] = 16'h7FFF;
      feats[4] = 16'h8000;
      feats[5] = 16'hFF00;
      for (int i = 6; i < NF; i++) feats[i] = 16'h0100;
      literal = {{10{2'b01}}, 2'b00, 2'b00, 2'b11, 2'b10, 2'b01, 2'b00};
      bus.m_ready = 1'b1;
      for (int i = 0; i < NF; i++) begin
         codes[i] = quant(feats[i]);
         push(feats[i], i == NF - 1, acc);
      end
      exp_vec = pack_codes();
      n_tests++;
      if (bus.m_valid !== 1'b1 || bus.err !== 1'b0) begin
         n_fail++;
         $display("FAIL sweep_flags: got mv=%b err=%b want 1/0", bus.m_valid, bus.err);
      end
      n_tests++;
      if (bus.M0 !== literal) begin
         n_fail++;
         $display("FAIL sweep_literal: got %h want %h", bus.M0, literal);
      end
      n_tests++;
      if (bus.M0 !== exp_vec) begin
         n_fail++;
         $display("FAIL sweep_model: got %h want %h", bus.M0, exp_vec);
      end
      idle();
      n_tests++;
      if (bus.m_valid !== 1'b0 || bus.M0 !== literal) begin
         n_fail++;
         $display("FAIL sweep_consumed: got mv=%b M0=%h want 0/%h", bus.m_valid, bus.M0, literal);
      end
   endtask

   task automatic test_backpressure();
      bit               acc;
      logic [15:0]      d;
      logic [NF*BW-1:0] vec_b;
      bus.m_ready = 1'b0;
      send_random_sample(1'b1);
      held_vec = exp_vec;
      for (int i = 0; i < NF - 1; i++) begin
         d        = 16'($urandom);
         codes[i] = quant(d);
         push(d, 1'b0, acc);
         n_tests++;
         if (acc !== 1'b1 || bus.m_valid !== 1'b1 || bus.M0 !== held_vec) begin
            n_fail++;
            $display("FAIL bp_collect[%0d]: got acc=%b mv=%b M0=%h want 1/1/%h",
                     i, acc, bus.m_valid, bus.M0, held_vec);
         end
      end
      d            = 16'($urandom);
      codes[NF-1]  = quant(d);
      vec_b        = pack_codes();
      bus.s_valid  = 1'b1;
      bus.s_data   = d;
      bus.s_last   = 1'b1;
      #1;
      for (int c = 0; c < 3; c++) begin
         n_tests++;
         if (bus.s_ready !== 1'b0 || bus.m_valid !== 1'b1 || bus.M0 !== held_vec) begin
            n_fail++;
            $display("FAIL bp_stall[%0d]: got rdy=%b mv=%b M0=%h want 0/1/%h",
                     c, bus.s_ready, bus.m_valid, bus.M0, held_vec);
         end
         if (c < 2) begin
            @(posedge clk);
            #1;
         end
      end
      bus.m_ready = 1'b1;
      #1;
      n_tests++;
      if (bus.s_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL bp_release_sready: got %b want 1", bus.s_ready);
      end
      @(posedge clk);
      #1;
      bus.s_valid = 1'b0;
      bus.s_last  = 1'b0;
      n_tests++;
      if (bus.m_valid !== 1'b1 || bus.M0 !== vec_b || bus.err !== 1'b0) begin
         n_fail++;
         $display("FAIL bp_new_vector: got mv=%b M0=%h err=%b want 1/%h/0",
                  bus.m_valid, bus.M0, bus.err, vec_b);
      end
      idle();
   endtask

   task automatic test_streaming();
      bit          acc;
      logic [15:0] d;
      bus.m_ready = 1'b1;
      for (int i = 0; i < 4 * NF; i++) begin
         d               = 16'($urandom);
         codes[i % NF]   = quant(d);
         push(d, (i % NF) == NF - 1, acc);
         n_tests++;
         if (acc !== 1'b1 || bus.m_valid !== ((i % NF) == NF - 1) || bus.err !== 1'b0) begin
            n_fail++;
            $display("FAIL stream[%0d]: got acc=%b mv=%b err=%b want 1/%b/0",
                     i, acc, bus.m_valid, bus.err, (i % NF) == NF - 1);
         end
         if ((i % NF) == NF - 1) begin
            exp_vec = pack_codes();
            n_tests++;
            if (bus.M0 !== exp_vec) begin
               n_fail++;
               $display("FAIL stream_vec[%0d]: got %h want %h", i / NF, bus.M0, exp_vec);
            end
         end
      end
      idle();
   endtask

   task automatic test_early_last();
      bit acc;
      bus.m_ready = 1'b1;
      for (int i = 0; i < 6; i++) push(16'($urandom), i == 5, acc);
      n_tests++;
      if (bus.err !== 1'b1 || bus.m_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL early_err: got err=%b mv=%b want 1/0", bus.err, bus.m_valid);
      end
      idle();
      n_tests++;
      if (bus.err !== 1'b0 || bus.m_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL early_pulse_end: got err=%b mv=%b want 0/0", bus.err, bus.m_valid);
      end
      send_random_sample(1'b1);
      n_tests++;
      if (bus.m_valid !== 1'b1 || bus.err !== 1'b0 || bus.M0 !== exp_vec) begin
         n_fail++;
         $display("FAIL early_recover: got mv=%b err=%b M0=%h want 1/0/%h",
                  bus.m_valid, bus.err, bus.M0, exp_vec);
      end
      idle();
   endtask

   task automatic test_missing_last();
      bus.m_ready = 1'b1;
      send_random_sample(1'b0);
      n_tests++;
      if (bus.m_valid !== 1'b1 || bus.err !== 1'b1 || bus.M0 !== exp_vec) begin
         n_fail++;
         $display("FAIL missing_last: got mv=%b err=%b M0=%h want 1/1/%h",
                  bus.m_valid, bus.err, bus.M0, exp_vec);
      end
      idle();
      n_tests++;
      if (bus.err !== 1'b0) begin
         n_fail++;
         $display("FAIL missing_last_pulse: got err=%b want 0", bus.err);
      end
   endtask

   task automatic test_reset_mid();
      bit acc;
      bus.m_ready = 1'b0;
      send_random_sample(1'b1);
      for (int i = 0; i < 9; i++) push(16'($urandom), 1'b0, acc);
      n_tests++;
      if (bus.m_valid !== 1'b1) begin
         n_fail++;
         $display("FAIL rstmid_pre: got mv=%b want 1", bus.m_valid);
      end
      #2;
      rst_n = 1'b0;
      #1;
      n_tests++;
      if (bus.m_valid !== 1'b0 || bus.M0 !== '0 || bus.err !== 1'b0 || bus.s_ready !== 1'b0) begin
         n_fail++;
         $display("FAIL rstmid_async: got mv=%b M0=%h err=%b rdy=%b want 0/0/0/0",
                  bus.m_valid, bus.M0, bus.err, bus.s_ready);
      end
      @(posedge clk);
      #2;
      rst_n       = 1'b1;
      bus.m_ready = 1'b1;
      idle();
      send_random_sample(1'b1);
      n_tests++;
      if (bus.m_valid !== 1'b1 || bus.err !== 1'b0 || bus.M0 !== exp_vec) begin
         n_fail++;
         $display("FAIL rstmid_fresh: got mv=%b err=%b M0=%h want 1/0/%h",
                  bus.m_valid, bus.err, bus.M0, exp_vec);
      end
      idle();
   endtask

   task automatic test_random();
      int               pq[$];
      bit               mv;
      bit               e;
      bit               sv;
      bit               mr;
      bit               lst;
      bit               exp_ready;
      logic [15:0]      d;
      logic [NF*BW-1:0] vec;
      bus.m_ready = 1'b1;
      idle();
      mv  = 1'b0;
      vec = bus.M0;
      for (int c = 0; c < 400; c++) begin
         sv  = ($urandom_range(0, 3) != 0);
         mr  = ($urandom_range(0, 2) != 0);
         d   = 16'($urandom);
         if (pq.size() == NF - 1) lst = ($urandom_range(0, 7) != 0);
         else lst = ($urandom_range(0, 15) == 0);
         bus.s_valid = sv;
         bus.s_data  = d;
         bus.s_last  = lst;
         bus.m_ready = mr;
         #1;
         exp_ready = !(pq.size() == NF - 1 && mv && !mr);
         n_tests++;
         if (bus.s_ready !== exp_ready) begin
            n_fail++;
            $display("FAIL rand_sready[%0d]: got %b want %b", c, bus.s_ready, exp_ready);
         end
         if (mv && mr) mv = 1'b0;
         e = 1'b0;
         if (sv && exp_ready) begin
            pq.push_back(quant(d));
            if (pq.size() == NF) begin
               for (int i = 0; i < NF; i++) vec[i*BW +: BW] = pq[i][BW-1:0];
               mv = 1'b1;
               e  = !lst;
               pq.delete();
            end else if (lst) begin
               pq.delete();
               e = 1'b1;
            end
         end
         @(posedge clk);
         #1;
         n_tests++;
         if (bus.m_valid !== mv || bus.err !== e || bus.M0 !== vec) begin
            n_fail++;
            $display("FAIL rand_out[%0d]: got mv=%b err=%b M0=%h want %b/%b/%h",
                     c, bus.m_valid, bus.err, bus.M0, mv, e, vec);
         end
      end
      bus.s_valid = 1'b0;
      bus.s_last  = 1'b0;
   endtask

   initial begin
      n_tests = 0;
      n_fail  = 0;
      test_reset();
      test_quant_sweep();
      test_backpressure();
      test_streaming();
      test_early_last();
      test_missing_last();
      test_reset_mid();
      test_random();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/input_quantizer.md
# input_quantizer

Streaming front-end for the classification network: accepts raw signed feature words one per cycle over a valid/ready handshake, quantizes each to a BW-bit unsigned code, packs NUM_FEATURES codes into one input vector and presents it, registered and held, to the layer-0 neuron LUTs. It sits directly upstream of layer 0. It supplies the packed M0 bus from which each layer-0 neuron takes its 6-bit input slice, decoupling the sensor/feature source from the purely combinational network.

## Interface
- NUM_FEATURES, 16, features per sample; must be ≥ 2.
- IN_W, 16, width of a raw signed feature word.
- BW, 2, bits per quantized code.
- OFFSET, 0, signed value subtracted before scaling, IN_W bits.
- SHIFT, 8, arithmetic right-shift applied after offset.
- clk  in  1  single clock; all state on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- s_valid  in  1  feature word valid.
- s_ready  out  1  block can accept a feature this cycle.
- s_data  in  IN_W  raw feature, two's complement.
- s_last  in  1  marks final feature of a sample.
- m_valid  out  1  packed vector valid.
- m_ready  in  1  downstream consumes vector.
- M0  out  NUM_FEATURES*BW  packed codes; feature i at bits [i*BW +: BW].
- err  out  1  one-cycle pulse on s_last framing mismatch.

## Operation
- Accept: a feature transfers when s_valid && s_ready.
- Quantize, combinational, per accepted word:
  - d = s_data − OFFSET, computed in IN_W+1 bits signed, no overflow.
  - q = d >>> SHIFT.
  - code = 0 if q < 0; 2^BW−1 if q > 2^BW−1; else q[BW−1:0].
- Index counter idx, 0..NUM_FEATURES−1.
  - Each accepted feature writes its code into the assembly register at slot idx, then idx increments.
  - Accepting at idx = NUM_FEATURES−1 completes the sample.
    - The assembly register, with the final code merged in, loads the output register.
    - m_valid is set and idx wraps to 0.
- s_ready = (idx != NUM_FEATURES−1) || !m_valid || m_ready. Forced 0 while rst_n low.
  - Collection of the next sample overlaps a held output.
  - Only the completing feature stalls.
- Output handshake:
  - m_valid && m_ready clears m_valid unless a new completion occurs in the same cycle; then m_valid stays 1 and M0 takes the new vector.
  - M0 holds its value while m_valid && !m_ready.
  - M0 retains its last value after consumption.
- Framing:
  - s_last accepted at idx < NUM_FEATURES−1: the partial sample is discarded, idx resets to 0, nothing is emitted, and err pulses.
  - Completion without s_last: the vector is still emitted and err pulses.
  - Completion with s_last: normal, no err.
- Assembly register is not cleared between samples; every slot is overwritten before each emission.

## Timing
- Reset values: m_valid=0, M0=0, err=0, idx=0, assembly register=0.
- Reset mid-sample discards the partial sample and any held vector.
- Latency: completing feature accepted in cycle t → m_valid=1 and M0 valid from cycle t+1.
- Throughput: one feature per cycle sustained when m_ready is held 1; one vector every NUM_FEATURES cycles.
- err is registered: it asserts in cycle t+1 for a violating accept in cycle t, for exactly one cycle.
- No combinational path from s_data to M0. s_ready depends combinationally on m_ready; that path is permitted, and m_ready must not depend on s_ready.

## Test plan
- Quantization sweep, defaults: features 0x0000, 0x0100, 0x02FF, 0x7FFF, 0x8000, 0xFF00, then 10×0x0100 with s_last on the 16th → M0 = {10×2'b01, 2'b00, 2'b00, 2'b11, 2'b10, 2'b01, 2'b00} (MSB first), m_valid=1 one cycle after the 16th accept, err=0.
- Back-pressure: m_ready=0 while a second sample streams.
  - s_ready drops only at idx=15, and M0 holds the first vector.
  - Raising m_ready accepts feature 15 that cycle; the new vector appears next cycle with m_valid continuously 1.
- Sustained streaming, m_ready=1, s_valid=1 for 64 cycles with s_last every 16th → four vectors, with m_valid high one cycle after each 16th accept and s_ready never low.
- Early s_last at idx=5 → err pulse one cycle later, no m_valid. The next 16 features produce a correct vector.
- Missing s_last at idx=15 → vector emitted normally and err pulses in the same cycle as m_valid rises.
- Reset asserted with idx=9 and m_valid=1 → outputs immediately 0 asynchronously. After release, a fresh 16-feature sample emits correctly.
